draw_scene_sequencer: RTL and testbench

- Initiator side of the draw handshake. Per frame, it issues one-cycle draw requests to the background, gold and stone draw FSMs in a fixed order, and waits for each `*_done` before the next request.
- It drives the object index that the object ROM/register file uses to present x/y to the gold/stone datapaths.
- It drives the VGA write-mux select.
- It sits between the game controller (`frame_start`, object-present masks) and the three draw FSMs.

---
 rtl/draw_scene_sequencer.sv | 166 ++++++++++++++++
 tb/tb_draw_scene_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_scene_sequencer.sv
// draw_scene_sequencer: per-frame initiator that requests background, gold and stone
// draws in a fixed order, waiting on each done with a timeout guard.
module draw_scene_sequencer #(
    parameter int          NUM_GOLD  = 8,
    parameter int          NUM_STONE = 4,
    parameter int          IDX_W     = 4,
    parameter logic [19:0] TIMEOUT   = 20'hFFFFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [NUM_GOLD-1:0]  gold_present,
    input  logic [NUM_STONE-1:0] stone_present,
    input  logic                 draw_background_done,
    input  logic                 draw_gold_done,
    input  logic                 draw_stone_done,
    output logic                 enable_draw_background,
    output logic                 enable_draw_gold,
    output logic                 enable_draw_stone,
    output logic [IDX_W-1:0]     obj_index,
    output logic [1:0]           draw_sel,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic                 draw_timeout
);
    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] BG_REQ     = 4'd1;
    localparam logic [3:0] BG_WAIT    = 4'd2;
    localparam logic [3:0] GOLD_SCAN  = 4'd3;
    localparam logic [3:0] GOLD_REQ   = 4'd4;
    localparam logic [3:0] GOLD_WAIT  = 4'd5;
    localparam logic [3:0] STONE_SCAN = 4'd6;
    localparam logic [3:0] STONE_REQ  = 4'd7;
    localparam logic [3:0] STONE_WAIT = 4'd8;
    localparam logic [3:0] FRAME_DONE = 4'd9;

    localparam logic [IDX_W-1:0] GOLD_END  = IDX_W'(NUM_GOLD);
    localparam logic [IDX_W-1:0] STONE_END = IDX_W'(NUM_STONE);
    localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

    logic [3:0]           state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 pending_q, pending_d;
    logic [NUM_GOLD-1:0]  gmask_q, gmask_d;
    logic [NUM_STONE-1:0] smask_q, smask_d;
    logic [19:0]          cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;
    logic                 gold_hit, stone_hit, expired;

    // An index past the last slot shifts the one-hot out, so the hit reads 0 there.
    assign gold_hit  = |(gmask_q & (NUM_GOLD'(1) << idx_q));
    assign stone_hit = |(smask_q & (NUM_STONE'(1) << idx_q));
    assign expired   = cnt_q == TIMEOUT - 20'd1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q | (frame_start & (state_q != IDLE));
        gmask_d   = gmask_q;
        smask_d   = smask_q;
        cnt_d     = cnt_q + 20'd1;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (frame_start | pending_q) begin
                    gmask_d   = gold_present;
                    smask_d   = stone_present;
                    pending_d = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = BG_REQ;
                end
            end
            BG_REQ: begin
                cnt_d   = '0;
                state_d = BG_WAIT;
            end
            BG_WAIT: begin
                if (draw_background_done) begin
                    idx_d   = '0;
                    state_d = GOLD_SCAN;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = FRAME_DONE;
                end
            end
            GOLD_SCAN: begin
                if (idx_q == GOLD_END) begin
                    idx_d   = '0;
                    state_d = STONE_SCAN;
                end else if (gold_hit) begin
                    state_d = GOLD_REQ;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            GOLD_REQ: begin
                cnt_d   = '0;
                state_d = GOLD_WAIT;
            end
            GOLD_WAIT: begin
                if (draw_gold_done) begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = GOLD_SCAN;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = FRAME_DONE;
                end
            end
            STONE_SCAN: begin
                if (idx_q == STONE_END) begin
                    state_d = FRAME_DONE;
                end else if (stone_hit) begin
                    state_d = STONE_REQ;
                end else begin
                    idx_d = idx_q + IDX_ONE;
                end
            end
            STONE_REQ: begin
                cnt_d   = '0;
                state_d = STONE_WAIT;
            end
            STONE_WAIT: begin
                if (draw_stone_done) begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = STONE_SCAN;
                end else if (expired) begin
                    timeout_d = 1'b1;
                    state_d   = FRAME_DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            gmask_q   <= '0;
            smask_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            gmask_q   <= gmask_d;
            smask_q   <= smask_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Requests last only the REQ state, which always moves on to WAIT next cycle.
    assign enable_draw_background = state_q == BG_REQ;
    assign enable_draw_gold       = state_q == GOLD_REQ;
    assign enable_draw_stone      = state_q == STONE_REQ;
    assign obj_index              = idx_q;
    assign frame_busy             = state_q != IDLE;
    assign frame_done             = state_q == FRAME_DONE;
    assign draw_timeout           = timeout_q;
    assign draw_sel = (state_q == BG_REQ    || state_q == BG_WAIT)    ? 2'd1 :
                      (state_q == GOLD_REQ  || state_q == GOLD_WAIT)  ? 2'd2 :
                      (state_q == STONE_REQ || state_q == STONE_WAIT) ? 2'd3 : 2'd0;
endmodule

// File: tb/tb_draw_scene_sequencer.sv
// tb_draw_scene_sequencer: frame table plus hand sequences; a scoreboard queue holds
// the expected {engine, draw_sel, obj_index} of every request in issue order.
module tb_draw_scene_sequencer;
    logic       clk = 1'b0;
    logic       reset, frame_start;
    logic [7:0] gold_present;
    logic [3:0] stone_present;
    logic       bg_done, gold_done, stone_done, gd_stray, sd_stray;
    logic       enable_draw_background, enable_draw_gold, enable_draw_stone;
    logic [3:0] obj_index;
    logic [1:0] draw_sel;
    logic       frame_busy, frame_done, draw_timeout;
    logic [11:0] outs;

    draw_scene_sequencer #(.NUM_GOLD(8), .NUM_STONE(4), .IDX_W(4), .TIMEOUT(20'd100)) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .gold_present(gold_present),
        .stone_present(stone_present),
        .draw_background_done(bg_done),
        .draw_gold_done(gold_done | gd_stray),
        .draw_stone_done(stone_done | sd_stray),
        .enable_draw_background(enable_draw_background),
        .enable_draw_gold(enable_draw_gold),
        .enable_draw_stone(enable_draw_stone),
        .obj_index(obj_index),
        .draw_sel(draw_sel),
        .frame_busy(frame_busy),
        .frame_done(frame_done),
        .draw_timeout(draw_timeout)
    );

    assign outs = {enable_draw_background, enable_draw_gold, enable_draw_stone, obj_index,
                   draw_sel, frame_busy, frame_done, draw_timeout};

    always #5 clk = ~clk;

    int vec = 0, bad = 0, cyc = 0, nfd = 0, fd_cyc = 0, bg_cyc = 0, t0 = 0;
    int d_bg = 3, d_g = 3, d_s = 3, cb = 0, cg = 0, cs = 0;
    logic [7:0] exp_q[$];
    logic [2:0] en, prev_en = 3'b000;
    logic [1:0] eng, hold_eng;
    logic [5:0] hold;
    logic       active = 1'b0;

    typedef struct { logic [7:0] g; logic [3:0] s; int d; int lat; } vec_t;
    vec_t tbl[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vec++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Responders register the request and pulse done d+1 cycles after it (d<0: never).
    // The monitor runs after them in the same process so it sees the current done.
    always @(negedge clk) begin
        bg_done = 1'b0;
        gold_done = 1'b0;
        stone_done = 1'b0;
        if (reset) begin
            cb = 0; cg = 0; cs = 0;
            active = 1'b0;
            prev_en = 3'b000;
        end else begin
            if (cb > 0) begin cb--; bg_done = (cb == 0); end
            if (cg > 0) begin cg--; gold_done = (cg == 0); end
            if (cs > 0) begin cs--; stone_done = (cs == 0); end
            if (enable_draw_background && d_bg >= 0) cb = d_bg + 1;
            if (enable_draw_gold && d_g >= 0) cg = d_g + 1;
            if (enable_draw_stone && d_s >= 0) cs = d_s + 1;
            if (frame_done) begin
                nfd++;
                fd_cyc = cyc;
                active = 1'b0;
            end
            en = {enable_draw_stone, enable_draw_gold, enable_draw_background};
            if (en != 3'b000) begin
                eng = enable_draw_background ? 2'd1 : enable_draw_gold ? 2'd2 : 2'd3;
                check("en_pulse", {29'd0, en & prev_en}, 0);
                check("en_onehot", $countones(en), 1);
                check("sb_pop", {31'd0, exp_q.size() != 0}, 1);
                if (exp_q.size() != 0)
                    check("sb_req", {24'd0, eng, draw_sel, (eng == 2'd1) ? 4'd0 : obj_index}, {24'd0, exp_q.pop_front()});
                hold = {draw_sel, obj_index};
                hold_eng = eng;
                active = 1'b1;
                if (enable_draw_background) bg_cyc = cyc;
            end else if (active) begin
                check("hold", {26'd0, draw_sel, obj_index}, {26'd0, hold});
                if ((hold_eng == 2'd1 && bg_done) || (hold_eng == 2'd2 && gold_done) ||
                    (hold_eng == 2'd3 && stone_done)) active = 1'b0;
            end
            prev_en = en;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_frame(input logic [7:0] g, input logic [3:0] s);
        exp_q.push_back({2'd1, 2'd1, 4'd0});
        for (int i = 0; i < 8; i++) if (g[i]) exp_q.push_back({2'd2, 2'd2, 4'(i)});
        for (int i = 0; i < 4; i++) if (s[i]) exp_q.push_back({2'd3, 2'd3, 4'(i)});
    endtask

    task automatic start_frame(input logic [7:0] g, input logic [3:0] s);
        gold_present = g;
        stone_present = s;
        frame_start = 1'b1;
        t0 = cyc;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_fd(input int target);
        for (int k = 0; k < 3000 && nfd < target; k++) tick();
        check("fd_count", nfd, target);
    endtask

    initial begin
        int n0, f1;
        // Latency = d + 8 + 4 + 5 + (drawn slots) * (d + 2)
        tbl[0] = '{8'h00, 4'h0, 3, 20};
        tbl[1] = '{8'h85, 4'h2, 35, 200};
        tbl[2] = '{8'hFF, 4'hF, 0, 41};
        tbl[3] = '{8'h01, 4'h0, 1, 21};
        tbl[4] = '{8'h00, 4'h8, 2, 23};
        tbl[5] = '{8'h80, 4'h1, 5, 36};
        reset = 1'b1; frame_start = 1'b0; gold_present = '0; stone_present = '0;
        gd_stray = 1'b0; sd_stray = 1'b0;
        tick(3);
        check("rst_outs", {20'd0, outs}, 0);
        reset = 1'b0;
        tick();
        check("idle_outs", {20'd0, outs}, 0);

        for (int i = 0; i < 6; i++) begin
            d_bg = tbl[i].d; d_g = tbl[i].d; d_s = tbl[i].d;
            push_frame(tbl[i].g, tbl[i].s);
            n0 = nfd;
            start_frame(tbl[i].g, tbl[i].s);
            check("bg_cycle", bg_cyc - t0, 1);
            wait_fd(n0 + 1);
            check("fd_lat", fd_cyc - t0, tbl[i].lat);
            check("sb_drain", exp_q.size(), 0);
            check("no_timeout", {31'd0, draw_timeout}, 0);
            tick(2);
        end

        // Two frame_start pulses while busy merge into one extra frame.
        d_bg = 3; d_g = 3; d_s = 3;
        push_frame(8'h00, 4'h0);
        push_frame(8'h00, 4'h0);
        n0 = nfd;
        start_frame(8'h00, 4'h0);
        tick(4);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        tick(3);
        frame_start = 1'b1; tick(); frame_start = 1'b0;
        wait_fd(n0 + 1);
        f1 = fd_cyc;
        wait_fd(n0 + 2);
        check("pend_start", bg_cyc - f1, 2);
        tick(40);
        check("pend_once", nfd, n0 + 2);
        check("pend_drain", exp_q.size(), 0);

        // Mask changes after acceptance are ignored.
        d_bg = 2; d_g = 2; d_s = 2;
        push_frame(8'h01, 4'h0);
        n0 = nfd;
        start_frame(8'h01, 4'h0);
        gold_present = 8'hFF;
        stone_present = 4'hF;
        wait_fd(n0 + 1);
        check("snap_lat", fd_cyc - t0, 23);
        check("snap_drain", exp_q.size(), 0);
        gold_present = '0;
        stone_present = '0;
        tick(2);

        // Gold never answers: abort after 100 GOLD_WAIT cycles.
        d_bg = 2; d_g = -1;
        push_frame(8'h01, 4'h0);
        n0 = nfd;
        start_frame(8'h01, 4'h0);
        wait_fd(n0 + 1);
        check("to_lat", fd_cyc - t0, 107);
        check("to_flag", {31'd0, draw_timeout}, 1);
        tick(5);
        check("to_sticky", {31'd0, draw_timeout}, 1);
        check("to_idle", {31'd0, frame_busy}, 0);
        d_g = 3;
        push_frame(8'h00, 4'h0);
        n0 = nfd;
        start_frame(8'h00, 4'h0);
        check("to_clear", {31'd0, draw_timeout}, 0);
        wait_fd(n0 + 1);
        check("to_next_lat", fd_cyc - t0, 19);
        tick(2);

        // Reset in GOLD_WAIT, then stray dones in IDLE.
        d_bg = 2; d_g = -1;
        push_frame(8'h01, 4'h0);
        start_frame(8'h01, 4'h0);
        tick(8);
        check("pre_rst_sel", {30'd0, draw_sel}, 2);
        check("pre_rst_busy", {31'd0, frame_busy}, 1);
        reset = 1'b1;
        tick();
        check("rst_mid", {20'd0, outs}, 0);
        reset = 1'b0;
        tick();
        check("rst_after", {20'd0, outs}, 0);
        check("rst_drain", exp_q.size(), 0);
        gd_stray = 1'b1; tick(); gd_stray = 1'b0;
        sd_stray = 1'b1; tick(); sd_stray = 1'b0;
        tick();
        check("stray_idle", {20'd0, outs}, 0);

        // Stone done during GOLD_WAIT must not advance the gold request.
        d_bg = 2; d_g = 20; d_s = 2;
        push_frame(8'h01, 4'h0);
        n0 = nfd;
        start_frame(8'h01, 4'h0);
        tick(9);
        sd_stray = 1'b1; tick(); sd_stray = 1'b0;
        check("stray_wait_sel", {30'd0, draw_sel}, 2);
        wait_fd(n0 + 1);
        check("stray_wait_lat", fd_cyc - t0, 41);
        check("stray_drain", exp_q.size(), 0);
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
